// File: rtl/rgb_dark_win_if.sv
// Video bundle for rgb_dark_win: input pixel/timing and the delayed dark-channel outputs.
// Frame statistics signals exist only when RGB_DARK_WIN_STAT_EN is defined.
`timescale 1ns/1ps
interface rgb_dark_win_if #(
  parameter int DW = 8,
  parameter int CH = 3
);
  logic [CH*DW-1:0] i_pix;
  logic             i_hsync;
  logic             i_vsync;
  logic             i_de;
  logic             i_bypass_win;
  logic [DW-1:0]    o_dark;
  logic             o_hsync;
  logic             o_vsync;
  logic             o_de;
`ifdef RGB_DARK_WIN_STAT_EN
  logic [DW-1:0]    o_frame_max;
  logic             o_frame_vld;
`endif

  modport slave (
    input  i_pix, i_hsync, i_vsync, i_de, i_bypass_win,
`ifdef RGB_DARK_WIN_STAT_EN
    output o_frame_max, o_frame_vld,
`endif
    output o_dark, o_hsync, o_vsync, o_de
  );

  modport master (
    output i_pix, i_hsync, i_vsync, i_de, i_bypass_win,
`ifdef RGB_DARK_WIN_STAT_EN
    input  o_frame_max, o_frame_vld,
`endif
    input  o_dark, o_hsync, o_vsync, o_de
  );
endinterface

// File: rtl/rgb_dark_win.sv
// Per-pixel channel minimum followed by a line-clipped horizontal window minimum, LAT = HALF + 2.
// Optional per-frame maximum statistics are enabled by defining RGB_DARK_WIN_STAT_EN.
`timescale 1ns/1ps
module rgb_dark_win #(
  parameter int DW  = 8,
  parameter int CH  = 3,
  parameter int WIN = 7
) (
  input  logic           pixelclk,
  input  logic           reset,
  rgb_dark_win_if.slave  vid
);
  localparam int HALF = (WIN - 1) / 2;
  localparam int LAT  = HALF + 2;
  localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO     = {DW{1'b0}};

  function automatic logic [DW-1:0] chan_min(input logic [CH*DW-1:0] pix);
    logic [DW-1:0] m;
    m = pix[CH*DW-1 -: DW];
    for (int k = 1; k < CH; k++) begin
      m = (pix[(CH-k)*DW-1 -: DW] < m) ? pix[(CH-k)*DW-1 -: DW] : m;
    end
    return m;
  endfunction

  logic            armed_q, armed_d;
  logic            seg_q, seg_d;
  logic            vld_in_s;
  logic [WIN-1:0]  tap_vld_q, tap_vld_d;
  logic [WIN-1:0]  tap_seg_q, tap_seg_d;
  logic [DW-1:0]   tap_pix_q [WIN];
  logic [DW-1:0]   tap_pix_d [WIN];
  logic [DW-1:0]   win_min_s;
  logic [LAT-1:0]  hs_q, hs_d;
  logic [LAT-1:0]  vs_q, vs_d;
  logic            de_q, de_d;
  logic [DW-1:0]   dark_q, dark_d;

  // Next-state for stage 1, the tap shift register, sync delays and the window output.
  always_comb begin
    // After reset, pixels are ignored until i_de has been seen low, so a cut line never leaks out.
    vld_in_s = vid.i_de & armed_q;
    armed_d  = armed_q | ~vid.i_de;
    seg_d    = seg_q ^ (vld_in_s & ~tap_vld_q[0]);

    tap_vld_d    = tap_vld_q;
    tap_seg_d    = tap_seg_q;
    tap_pix_d    = tap_pix_q;
    tap_vld_d[0] = vld_in_s;
    tap_seg_d[0] = seg_d;
    tap_pix_d[0] = chan_min(vid.i_pix);
    for (int j = 1; j < WIN; j++) begin
      tap_vld_d[j] = tap_vld_q[j-1];
      tap_seg_d[j] = tap_seg_q[j-1];
      tap_pix_d[j] = tap_pix_q[j-1];
    end

    hs_d = {hs_q[LAT-2:0], vid.i_hsync};
    vs_d = {vs_q[LAT-2:0], vid.i_vsync};

    // Taps from another segment or outside active video count as all-ones.
    win_min_s = ALL_ONES;
    for (int j = 0; j < WIN; j++) begin
      win_min_s = (tap_vld_q[j] && (tap_seg_q[j] == tap_seg_q[HALF]) && (tap_pix_q[j] < win_min_s))
                  ? tap_pix_q[j] : win_min_s;
    end

    de_d = tap_vld_q[HALF];
    if (!tap_vld_q[HALF]) begin
      dark_d = ZERO;
    end else if (vid.i_bypass_win) begin
      dark_d = tap_pix_q[HALF];
    end else begin
      dark_d = win_min_s;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      armed_q   <= 1'b0;
      seg_q     <= 1'b0;
      tap_vld_q <= {WIN{1'b0}};
      tap_seg_q <= {WIN{1'b0}};
      tap_pix_q <= '{default: ZERO};
      hs_q      <= {LAT{1'b0}};
      vs_q      <= {LAT{1'b0}};
      de_q      <= 1'b0;
      dark_q    <= ZERO;
    end else begin
      armed_q   <= armed_d;
      seg_q     <= seg_d;
      tap_vld_q <= tap_vld_d;
      tap_seg_q <= tap_seg_d;
      tap_pix_q <= tap_pix_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      dark_q    <= dark_d;
    end
  end

  assign vid.o_dark  = dark_q;
  assign vid.o_de    = de_q;
  assign vid.o_hsync = hs_q[LAT-1];
  assign vid.o_vsync = vs_q[LAT-1];

`ifdef RGB_DARK_WIN_STAT_EN
  logic          vs_prev_q, vs_prev_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] fmax_q, fmax_d;
  logic          fvld_q, fvld_d;
  logic          vs_rise_s;

  // Frame maximum tracking; an output pixel coincident with the vsync edge opens the new frame.
  always_comb begin
    vs_rise_s = vs_q[LAT-1] & ~vs_prev_q;
    vs_prev_d = vs_q[LAT-1];
    if (vs_rise_s) begin
      fmax_d = acc_q;
      fvld_d = 1'b1;
      acc_d  = de_q ? dark_q : ZERO;
    end else begin
      fmax_d = fmax_q;
      fvld_d = 1'b0;
      acc_d  = (de_q && (dark_q > acc_q)) ? dark_q : acc_q;
    end
  end

  // Statistics registers with synchronous reset.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      vs_prev_q <= 1'b0;
      acc_q     <= ZERO;
      fmax_q    <= ZERO;
      fvld_q    <= 1'b0;
    end else begin
      vs_prev_q <= vs_prev_d;
      acc_q     <= acc_d;
      fmax_q    <= fmax_d;
      fvld_q    <= fvld_d;
    end
  end

  assign vid.o_frame_max = fmax_q;
  assign vid.o_frame_vld = fvld_q;
`endif
endmodule

// File: tb/tb_rgb_dark_win.sv
// Bench for rgb_dark_win: table of pixel rows with hand-derived window minima fed through a
// latency-aware scoreboard, plus hand sequences for reset mid-line, a WIN=3 instance and statistics.
`timescale 1ns/1ps
module tb_rgb_dark_win;
  localparam int LAT0 = 5;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst0, rst1;
  logic        d1_de;
  logic [39:0] d1_pix;

  rgb_dark_win_if #(.DW(8),  .CH(3)) vid0 ();
  rgb_dark_win_if #(.DW(10), .CH(4)) vid1 ();

  rgb_dark_win #(.DW(8),  .CH(3), .WIN(7)) dut0 (.pixelclk(clk), .reset(rst0), .vid(vid0));
  rgb_dark_win #(.DW(10), .CH(4), .WIN(3)) dut1 (.pixelclk(clk), .reset(rst1), .vid(vid1));

  typedef struct {
    logic        de;
    logic [23:0] pix;
    logic        byp;
    logic [7:0]  exp;
  } row_t;

  typedef struct {
    int         due;
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] dark;
  } sb_t;

  row_t rows[$];
  sb_t  sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic de, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic byp, input logic [7:0] exp);
    row_t t;
    t.de  = de;
    t.pix = {r, g, b};
    t.byp = byp;
    t.exp = exp;
    rows.push_back(t);
  endtask

  task automatic add_idle(input int n, input logic byp);
    for (int i = 0; i < n; i++) add(1'b0, 8'd0, 8'd0, 8'd0, byp, 8'd0);
  endtask

  // One clock: drive after the edge, optionally log an expectation, check due entries at negedge.
  task automatic step(input logic rst, input logic de, input logic [23:0] pix, input logic hs,
                      input logic vs, input logic byp, input logic push, input logic [7:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst0              = rst;
    vid0.i_de         = de;
    vid0.i_pix        = pix;
    vid0.i_hsync      = hs;
    vid0.i_vsync      = vs;
    vid0.i_bypass_win = byp;
    vid1.i_de         = d1_de;
    vid1.i_pix        = d1_pix;
    if (push) begin
      e.due  = cyc + LAT0;
      e.de   = de;
      e.hs   = hs;
      e.vs   = vs;
      e.dark = exp;
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("sb_out", {21'd0, vid0.o_dark, vid0.o_de, vid0.o_hsync, vid0.o_vsync},
                    {21'd0, e.dark, e.de, e.hs, e.vs});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e2;
    int         cnt;
    logic [7:0] got;
    logic       de_s;
    logic [23:0] pix_s;
    logic [7:0] exp_d;
    logic       exp_e;

    // ---- stimulus table ----
    add_idle(6, 1'b0);
    add(1'b1, 8'd200, 8'd50, 8'd120, 1'b0, 8'd50);
    add_idle(8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      e2 = (i < 2 || i == 9) ? 8'd100 : 8'd10;
      if (i == 5)          add(1'b1, 8'd90, 8'd77, 8'd10, 1'b0, e2);
      else if (i % 2 == 1) add(1'b1, 8'd180, 8'd100, 8'd255, 1'b0, e2);
      else                 add(1'b1, 8'd100, 8'd150, 8'd220, 1'b0, e2);
    end
    add_idle(2, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b1, 8'd20, 8'd90, 8'd60, 1'b0, 8'd20);
    add_idle(1, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b1, 8'd230, 8'd200, 8'd210, 1'b0, 8'd200);
    add_idle(8, 1'b0);
    add_idle(6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5)          add(1'b1, 8'd90, 8'd77, 8'd10, 1'b1, 8'd10);
      else if (i % 2 == 1) add(1'b1, 8'd180, 8'd100, 8'd255, 1'b1, 8'd100);
      else                 add(1'b1, 8'd100, 8'd150, 8'd220, 1'b1, 8'd100);
    end
    add_idle(8, 1'b1);
    add_idle(6, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b1, 8'd77, 8'd77, 8'd77, 1'b0, 8'd77);
    add_idle(2, 1'b0);
    add(1'b1, 8'd40, 8'd90, 8'd90, 1'b0, 8'd40);
    add_idle(1, 1'b0);
    add(1'b1, 8'd90, 8'd60, 8'd90, 1'b0, 8'd60);
    add_idle(1, 1'b0);
    add(1'b1, 8'd90, 8'd90, 8'd80, 1'b0, 8'd80);
    add_idle(2, 1'b0);
    add(1'b1, 8'd30, 8'd40, 8'd50, 1'b0, 8'd15);
    add(1'b1, 8'd90, 8'd80, 8'd70, 1'b0, 8'd15);
    add(1'b1, 8'd60, 8'd15, 8'd99, 1'b0, 8'd15);
    add_idle(3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      e2 = 8'(50 + 10 * ((i > 3) ? i - 3 : 0));
      add(1'b1, 8'(50 + 10 * i), 8'd250, 8'd251, 1'b0, e2);
    end
    add_idle(8, 1'b0);

    // ---- reset state ----
    d1_de  = 1'b1;
    d1_pix = {40{1'b1}};
    rst1   = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("reset_dut0", {22'd0, vid0.o_dark, vid0.o_de, vid0.o_hsync, vid0.o_vsync}, 32'd0);
    chk("reset_dut1", {19'd0, vid1.o_dark, vid1.o_de, vid1.o_hsync, vid1.o_vsync}, 32'd0);
    d1_de  = 1'b0;
    d1_pix = 40'd0;
    rst1   = 1'b0;
    idle(8);

    // ---- table through scoreboard ----
    foreach (rows[i]) begin
      step(1'b0, rows[i].de, rows[i].pix, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rows[i].byp, 1'b1, rows[i].exp);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    chk("sb_drain", sb.size(), 32'd0);
    idle(4);

    // ---- reset in the middle of a 20-pixel line ----
    for (int s = 0; s < 40; s++) begin
      de_s  = (s <= 19) || (s >= 23 && s <= 26);
      pix_s = (s < 20) ? {8'd100, 8'd140, 8'd180} : {8'd90, 8'd60, 8'd200};
      step((s == 8), de_s, pix_s, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      exp_e = (s >= 5 && s <= 8) || (s >= 28 && s <= 31);
      exp_d = exp_e ? ((s <= 8) ? 8'd100 : 8'd60) : 8'd0;
      chk("rst_seq", {23'd0, vid0.o_de, vid0.o_dark}, {23'd0, exp_e, exp_d});
    end

    // ---- WIN=3, DW=10, CH=4 instance ----
    for (int s = 0; s < 13; s++) begin
      d1_de  = (s >= 3 && s <= 5);
      d1_pix = (s == 4) ? {10'd1023, 10'd512, 10'd7, 10'd900} : {4{10'd1023}};
      step(1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      exp_e = (s >= 3 + LAT1 && s <= 5 + LAT1);
      chk("win3_seq", {21'd0, vid1.o_de, vid1.o_dark}, {21'd0, exp_e, exp_e ? 10'd7 : 10'd0});
    end
    d1_de  = 1'b0;
    d1_pix = 40'd0;

`ifdef RGB_DARK_WIN_STAT_EN
    // ---- frame statistics ----
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(12);
    step(1'b0, 1'b1, {8'd173, 8'd200, 8'd180}, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(1);
    step(1'b0, 1'b1, {8'd100, 8'd120, 8'd140}, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(10);
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      got = 8'hEE;
      for (int i = 0; i < 20; i++) begin
        step(1'b0, 1'b0, 24'd0, 1'b0, (i < 3), 1'b0, 1'b0, 8'd0);
        if (vid0.o_frame_vld) begin
          cnt++;
          got = vid0.o_frame_max;
        end
      end
      chk("stat_vld_pulses", cnt, 32'd1);
      chk("stat_frame_max", {24'd0, got}, (f == 0) ? 32'd173 : 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_dark_win.md
Name: rgb_dark_win

Overview:
Parametrised successor to the per-pixel dark-channel stage. Computes the minimum across CH colour channels per pixel, then a horizontal sliding-window minimum of WIN pixels centred on each pixel, clipped to the active line. Sits between video input timing and the transmission-estimate stage of the dehaze pipeline. Sync and DE are delayed to stay aligned with the output data.

Parameters:
DW, 8, bits per colour channel
CH, 3, number of colour channels (2..4)
WIN, 7, horizontal window width; odd, 1..15; HALF = (WIN-1)/2

Ports:
pixelclk  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
i_pix  in  CH*DW  pixel; channel k at bits [(CH-k)*DW-1 -: DW], so channel 0 (R) is in the MSBs
i_hsync  in  1  horizontal sync
i_vsync  in  1  vertical sync, active-high
i_de  in  1  data enable, active video
i_bypass_win  in  1  1 = window forced to 1 pixel; latency unchanged
o_dark  out  DW  windowed dark-channel value
o_hsync  out  1  i_hsync delayed by LAT
o_vsync  out  1  i_vsync delayed by LAT
o_de  out  1  i_de delayed by LAT

Behaviour:
- Reset is synchronous and active-high. It clears all pipeline, sync and DE registers, marks all window taps invalid, and clears the segment tag. All outputs read 0 in the cycle after reset is sampled high.
- Latency: LAT = HALF + 2 cycles for all parameter values (WIN=7 gives LAT=5). o_hsync, o_vsync and o_de are pure LAT-deep delays of their inputs.
- Stage 1, registered: cmin = unsigned minimum over CH channels. The register stores cmin, de and seg.
- Segment tag seg: a 1-bit register that toggles on every rising edge of i_de (i_de=1 while the previous i_de=0). seg is attached to each pixel entering stage 1.
- Stage 2: a WIN-deep shift register of {valid, seg, cmin} entries, shifting every cycle. valid is the stage-1 de.
- Centre tap = index HALF.
- Window output register: min over taps j where valid_j=1 and seg_j equals seg_centre. All other taps are treated as all-ones (2^DW-1).
- Effect of the tagging: no leakage across lines or de gaps; line edges are clipped; de gaps of any length, including 1 cycle, act as boundaries.
- i_bypass_win=1: the output is cmin_centre only. The input is sampled per cycle at the centre tap and is intended to change only during vsync.
- o_dark = 0 in every cycle where o_de = 0. This includes the case where the centre tap is invalid.
- Ties and equal values: plain unsigned min, deterministic.
- Single-pixel line (de high 1 cycle): o_dark = that pixel's cmin.
- Reset mid-line: in-flight pixels are discarded, not output. The first post-reset output appears LAT cycles after the first post-reset de.
- Continuous operation: no back-pressure, one pixel per clock, no stalls.

Optional Feature:
Macro RGB_DARK_WIN_STAT_EN.
- Defined: adds ports o_frame_max (out, DW) and o_frame_vld (out, 1).
- An accumulator tracks the maximum o_dark over cycles with o_de=1.
- On the rising edge of o_vsync: the accumulator is copied to o_frame_max, o_frame_vld pulses high for exactly 1 cycle, and the accumulator clears to 0.
- If o_de=1 in the same cycle as that edge, that pixel counts toward the new frame.
- Reset clears the accumulator, o_frame_max and o_frame_vld.
- Undefined: the ports and logic are absent; the core behaviour is identical.

Test Plan:
1. Defaults (DW=8, CH=3, WIN=7): one de cycle with pixel (200,50,120) -> o_de high for 1 cycle, 5 cycles later, with o_dark=50; o_dark=0 in all other cycles.
2. 10-pixel line, every pixel cmin=100 except index 5 with cmin=10 -> outputs idx0..1=100, idx2..8=10, idx9=100.
3. Line A of 8 pixels all cmin=20, 1-cycle de gap, line B of 8 pixels all cmin=200 -> all B outputs=200 and all A outputs=20, with no cross-line leakage. Repeat with i_bypass_win=1 on scenario 2 -> only idx5=10.
4. Assert reset for 1 cycle in the middle of a 20-pixel line -> all outputs 0 from the next cycle; remaining line pixels produce no output; the next line behaves normally.
5. Instance with DW=10, CH=4, WIN=3: pixel (1023,512,7,900) in a 3-pixel line with neighbours all 1023 -> centre output=7, neighbour outputs=7; LAT=3.
6. With RGB_DARK_WIN_STAT_EN defined: a frame whose maximum o_dark is 173 -> at the next o_vsync rising edge, o_frame_vld pulses for 1 cycle with o_frame_max=173; the next frame, all 0, reports 0.
